// File: rtl/vram_cmd_dispatch.sv
// vram_cmd_dispatch: byte-stream front end for vram_control.
//   Buffers host (opcode, arg) byte pairs in an RX FIFO and strobes each pair into
//   vram_control only while it is idle. Single-byte responses from vram_control are
//   queued in a TX FIFO for the host link.
// Ports:
//   clock, reset_n                 - single clock, async active-low reset
//   rx_data_i/rx_valid_i/rx_ready_o - host command bytes in (valid/ready)
//   tx_data_o/tx_valid_o/tx_ready_i - response bytes out (valid/ready)
//   cmd_data_o/cmd_valid_o          - byte strobe to vram_control read_data_i/read_valid_i
//   busy_i                          - vram_control busy_o
//   resp_data_i/resp_valid_i        - vram_control write_data_o/write_valid_o
//   clear_errors_i                  - synchronous clear of the sticky error flags
//   error_tx_overflow_o             - sticky: response arrived with TX FIFO full
//   error_timeout_o                 - sticky: command stayed busy too long
// Build option: define VRAM_CMD_TIMEOUT_EN to enable the busy timeout watchdog.

// Generic FIFO with registered read/write pointers carrying one extra wrap bit.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: pushes while full and pops while empty are ignored; the caller gates them.
module vram_cmd_fifo #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  head_dat,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    // Wrap bits differ with equal index bits: writer is a full lap ahead.
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty    = (wr_ptr == rd_ptr);
    assign level    = wr_ptr - rd_ptr;
    assign head_dat = mem[rd_ptr[AW-1:0]];
    assign do_push  = push && !full;
    // A pop against an empty FIFO has no head to remove; a same-cycle push still lands.
    assign do_pop   = pop && !empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_dat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// Dispatcher: releases buffered (opcode, arg) pairs to vram_control and queues responses.
// Latency: opcode strobe one cycle after a full pair is buffered and the dispatcher is idle.
// Backpressure: rx_ready_o drops when RX is full; no dispatch while busy_i or TX has no free slot.
module vram_cmd_dispatch #(
    parameter int RX_DEPTH_LOG2  = 4,
    parameter int TX_DEPTH_LOG2  = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] rx_data_i,
    input  logic       rx_valid_i,
    output logic       rx_ready_o,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic [7:0] cmd_data_o,
    output logic       cmd_valid_o,
    input  logic       busy_i,
    input  logic [7:0] resp_data_i,
    input  logic       resp_valid_i,
    input  logic       clear_errors_i,
    output logic       error_tx_overflow_o,
    output logic       error_timeout_o
);
    typedef enum logic [3:0] {
        S_IDLE = 4'b0001,
        S_OP   = 4'b0010,
        S_ARG  = 4'b0100,
        S_WAIT = 4'b1000
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   wait_first;
    logic   timeout_hit;

    logic [7:0]             rx_head_dat;
    logic                   rx_full;
    logic                   rx_unused_empty;
    logic [RX_DEPTH_LOG2:0] rx_level;
    logic                   rx_pop;

    logic                   tx_full;
    logic                   tx_empty;
    logic [TX_DEPTH_LOG2:0] tx_unused_level;

    assign rx_ready_o = !rx_full;
    assign tx_valid_o = !tx_empty;

    vram_cmd_fifo #(.AW(RX_DEPTH_LOG2), .W(8)) u_rx_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (rx_valid_i && rx_ready_o),
        .push_dat (rx_data_i),
        .pop      (rx_pop),
        .head_dat (rx_head_dat),
        .full     (rx_full),
        .empty    (rx_unused_empty),
        .level    (rx_level)
    );

    // A response arriving while TX is full is dropped even if the host pops that cycle.
    vram_cmd_fifo #(.AW(TX_DEPTH_LOG2), .W(8)) u_tx_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (resp_valid_i),
        .push_dat (resp_data_i),
        .pop      (tx_ready_i && tx_valid_o),
        .head_dat (tx_data_o),
        .full     (tx_full),
        .empty    (tx_empty),
        .level    (tx_unused_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            wait_first <= 1'b0;
        end else begin
            state      <= state_nxt;
            wait_first <= (state == S_ARG);
        end
    end

    always_comb begin
        state_nxt   = state;
        cmd_valid_o = 1'b0;
        cmd_data_o  = 8'h00;
        rx_pop      = 1'b0;
        case (state)
            S_IDLE: begin
                // Whole pair buffered, controller free, and room for its one response.
                if ((rx_level >= (RX_DEPTH_LOG2+1)'(2)) && !busy_i && !tx_full) begin
                    state_nxt = S_OP;
                end
            end
            S_OP: begin
                cmd_valid_o = 1'b1;
                cmd_data_o  = rx_head_dat;
                rx_pop      = 1'b1;
                state_nxt   = S_ARG;
            end
            S_ARG: begin
                cmd_valid_o = 1'b1;
                cmd_data_o  = rx_head_dat;
                rx_pop      = 1'b1;
                state_nxt   = S_WAIT;
            end
            S_WAIT: begin
                // busy_i lags the arg strobe by a cycle, so the first wait cycle ignores it.
                if (timeout_hit) begin
                    state_nxt = S_IDLE;
                end else if (!wait_first && !busy_i) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef VRAM_CMD_TIMEOUT_EN
    logic [7:0] timeout_cnt;
    logic       timeout_err;

    // Fires on the busy cycle that brings the count up to TIMEOUT_CYCLES.
    assign timeout_hit     = (state == S_WAIT) && busy_i &&
                             (timeout_cnt == 8'(TIMEOUT_CYCLES - 1));
    assign error_timeout_o = timeout_err;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            timeout_cnt <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            if (state == S_OP) begin
                timeout_cnt <= 8'h00;
            end else if ((state == S_WAIT) && busy_i) begin
                timeout_cnt <= timeout_cnt + 8'h01;
            end
            if (clear_errors_i) begin
                timeout_err <= 1'b0;
            end else if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    // Without the watchdog S_WAIT waits on busy_i forever; the limit is not used.
    assign unused_timeout_cfg = ^8'(TIMEOUT_CYCLES);
    assign timeout_hit        = 1'b0;
    assign error_timeout_o    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            error_tx_overflow_o <= 1'b0;
        end else if (clear_errors_i) begin
            error_tx_overflow_o <= 1'b0;
        end else if (resp_valid_i && tx_full) begin
            error_tx_overflow_o <= 1'b1;
        end
    end
endmodule
